// File: rtl/nasti_aw_burst_gen_pkg.sv
// Shared definitions for the NASTI AW burst generator: burst encodings,
// width limits, FSM state type and a small request-legality helper.
package nasti_aw_burst_gen_pkg;

  localparam int MAX_NASTI_ID_WIDTH   = 16;
  localparam int MAX_NASTI_ADDR_WIDTH = 64;
  localparam int MAX_NASTI_USER_WIDTH = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/nasti_aw_burst_gen_if.sv
// AW request channel plus per-beat address channel of the burst generator.
// The slave modport is the generator's view, master is the surrounding logic.
interface nasti_aw_burst_gen_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 1
) ();

  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic [USER_WIDTH-1:0] aw_user;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [ID_WIDTH-1:0]   beat_id;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [USER_WIDTH-1:0] beat_user;
  logic [7:0]            beat_idx;
  logic                  beat_last;
  logic                  beat_err;
  logic                  beat_valid;
  logic                  beat_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    input  aw_ready,
    input  beat_id, beat_addr, beat_user, beat_idx, beat_last, beat_err, beat_valid,
    output beat_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    output aw_ready,
    output beat_id, beat_addr, beat_user, beat_idx, beat_last, beat_err, beat_valid,
    input  beat_ready
  );

endinterface

// File: rtl/nasti_aw_burst_gen_beat_addr_calc.sv
// Combinational next-beat address for FIXED, INCR and WRAP sequencing.
// Callers pass INCR for errored bursts so their W data still drains.
module nasti_beat_addr_calc
  import nasti_aw_burst_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  input  logic [7:0]            len,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] sz;
  logic [ADDR_WIDTH-1:0] span_mask;
  logic [ADDR_WIDTH-1:0] aligned;

  always_comb begin
    sz        = ADDR_WIDTH'(1) << size;
    span_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    aligned   = cur_addr & ~(sz - ADDR_WIDTH'(1));
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = base | ((cur_addr + sz) & span_mask);
      // Aligning first lets an unaligned INCR start land on the next boundary.
      default:     next_addr = aligned + sz;
    endcase
  end

endmodule

// File: rtl/nasti_aw_burst_gen.sv
// NASTI AW consumer: accepts one write-address request and emits len+1 beat
// addresses, with zero-bubble hand-over between back-to-back bursts.
module nasti_aw_burst_gen
  import nasti_aw_burst_gen_pkg::*;
#(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DATA_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  nasti_aw_burst_gen_if.slave  bus
);

  localparam logic [3:0] DB_LOG2 = 4'($clog2(DATA_BYTES));

  state_t state, state_nxt;
  logic   aw_hs, beat_hs, load, advance;

  logic [ID_WIDTH-1:0]   id_p0;
  logic [USER_WIDTH-1:0] user_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [ADDR_WIDTH-1:0] base_p0;
  logic [7:0]            len_p0;
  logic [7:0]            idx_p0;
  logic [2:0]            size_p0;
  logic [1:0]            burst_p0;
  logic                  err_p0;

  logic [ADDR_WIDTH-1:0] req_sz;
  logic [ADDR_WIDTH-1:0] req_span_mask;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Request decode, evaluated against the live AW fields at handshake time.
  always_comb begin
    req_sz        = ADDR_WIDTH'(1) << bus.aw_size;
    req_span_mask = ((ADDR_WIDTH'(bus.aw_len) + ADDR_WIDTH'(1)) << bus.aw_size)
                    - ADDR_WIDTH'(1);
    req_err = 1'b0;
    if (bus.aw_burst == BURST_RSVD)        req_err = 1'b1;
    if ({1'b0, bus.aw_size} > DB_LOG2)     req_err = 1'b1;
    if (bus.aw_burst == BURST_WRAP) begin
      if (!wrap_len_ok(bus.aw_len))                       req_err = 1'b1;
      if (|(bus.aw_addr & (req_sz - ADDR_WIDTH'(1))))     req_err = 1'b1;
    end
  end

  assign bus.beat_valid = (state == ST_BURST);
  assign bus.beat_last  = (idx_p0 == len_p0);
  assign bus.beat_id    = id_p0;
  assign bus.beat_user  = user_p0;
  assign bus.beat_addr  = addr_p0;
  assign bus.beat_idx   = idx_p0;
  assign bus.beat_err   = err_p0;

  // Ready is a function of state and the beat handshake only, never aw_valid.
  assign bus.aw_ready = !rst && ((state == ST_IDLE) ||
                                 (bus.beat_valid && bus.beat_last && bus.beat_ready));
  assign aw_hs   = bus.aw_valid && bus.aw_ready;
  assign beat_hs = bus.beat_valid && bus.beat_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (aw_hs) begin
          state_nxt = ST_BURST;
          load      = 1'b1;
        end
      end
      ST_BURST: begin
        if (beat_hs) begin
          if (bus.beat_last) begin
            if (aw_hs) load      = 1'b1;
            else       state_nxt = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  nasti_beat_addr_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_calc (
    .cur_addr  (addr_p0),
    .size      (size_p0),
    .burst     (burst_p0),
    .len       (len_p0),
    .base      (base_p0),
    .next_addr (next_addr)
  );

  // Captured request / current beat stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_p0    <= '0;
      user_p0  <= '0;
      addr_p0  <= '0;
      base_p0  <= '0;
      len_p0   <= '0;
      idx_p0   <= '0;
      size_p0  <= '0;
      burst_p0 <= '0;
      err_p0   <= 1'b0;
    end else if (load) begin
      id_p0    <= bus.aw_id;
      user_p0  <= bus.aw_user;
      addr_p0  <= bus.aw_addr;
      base_p0  <= bus.aw_addr & ~req_span_mask;
      len_p0   <= bus.aw_len;
      idx_p0   <= 8'd0;
      size_p0  <= bus.aw_size;
      burst_p0 <= req_err ? BURST_INCR : bus.aw_burst;
      err_p0   <= req_err;
    end else if (advance) begin
      addr_p0 <= next_addr;
      idx_p0  <= idx_p0 + 8'd1;
    end
  end

endmodule
